// File: rtl/remora_frame_pkg.sv
// Shared constants and helpers for the Remora SPI frame format.
// Multi-byte fields travel little-endian on the wire.
package remora_frame_pkg;

  localparam logic [31:0] HEADER_RX = 32'h77726974;  // "writ"
  localparam logic [31:0] HEADER_TX = 32'h64617461;  // "data"

  localparam int unsigned HDR_W   = 32;
  localparam int unsigned JOINT_W = 32;
  localparam int unsigned VOUT_W  = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic {
    ST_IDLE,
    ST_CHECK
  } dec_state_t;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [15:0] swap16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Down-counting frame watchdog: reloads on kick, stops at zero.
// timeout is high whenever the counter has reached zero, including out of reset.
module frame_watchdog #(
  parameter logic [31:0] WDT_CYCLES = 32'd2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic timeout
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (kick) begin
      count_q <= WDT_CYCLES;
    end else if (count_q != '0) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign timeout = (count_q == '0);

endmodule

// File: rtl/spi_rx_frame_decoder.sv
// Captures a received SPI frame on the pkg_ok rising edge, validates the header
// and latches the byte-swapped command fields; a watchdog forces safe outputs.
module spi_rx_frame_decoder #(
  parameter int unsigned BUFFER_SIZE = 96,
  parameter logic [31:0] HEADER_RX   = remora_frame_pkg::HEADER_RX,
  parameter int unsigned JOINTS      = 1,
  parameter int unsigned VOUTS       = 1,
  parameter int unsigned DOUTS       = 8,
  parameter logic [31:0] WDT_CYCLES  = 32'd2500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BUFFER_SIZE-1:0] rx_data,
  input  logic                   pkg_ok,
  output logic [32*JOINTS-1:0]   jointFreqCmd,
  output logic [JOINTS-1:0]      jointEnable,
  output logic [16*VOUTS-1:0]    setPoint,
  output logic [DOUTS-1:0]       dout,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   wdt_timeout,
  output logic [15:0]            err_cnt
);

  import remora_frame_pkg::*;

  localparam int unsigned JOINT_TOP = BUFFER_SIZE - HDR_W;
  localparam int unsigned VOUT_TOP  = JOINT_TOP - JOINT_W * JOINTS;
  localparam int unsigned EN_TOP    = VOUT_TOP - VOUT_W * VOUTS;
  localparam int unsigned EN_W      = BYTE_W * ((JOINTS + 7) / 8);
  localparam int unsigned DOUT_TOP  = EN_TOP - EN_W;
  localparam int unsigned DOUT_W    = BYTE_W * ((DOUTS + 7) / 8);

  dec_state_t state_q, state_d;

  logic                   pkg_ok_q;
  logic [BUFFER_SIZE-1:0] shadow;
  logic                   capture, accept, reject;
  logic                   header_ok;

  logic [32*JOINTS-1:0] joint_rx, joint_q;
  logic [JOINTS-1:0]    enable_rx, enable_q;
  logic [16*VOUTS-1:0]  vout_rx, vout_q;
  logic [DOUTS-1:0]     dout_rx, dout_q;
  logic                 frame_valid_q, frame_err_q;
  logic [15:0]          err_cnt_q;

  // Padding bits of the enable/dout fields and any trailing bits carry no data.
  logic unused_shadow;
  assign unused_shadow = ^shadow;

  assign header_ok = (swap32(shadow[BUFFER_SIZE-1 -: 32]) == HEADER_RX);

  for (genvar j = 0; j < JOINTS; j++) begin : g_joint
    assign joint_rx[32*j +: 32] = swap32(shadow[JOINT_TOP-1-32*j -: 32]);
    assign enable_rx[j]         = shadow[EN_TOP-1-j];
  end

  for (genvar v = 0; v < VOUTS; v++) begin : g_vout
    assign vout_rx[16*v +: 16] = swap16(shadow[VOUT_TOP-1-16*v -: 16]);
  end

  for (genvar n = 0; n < DOUTS; n++) begin : g_dout
    assign dout_rx[n] = shadow[DOUT_TOP-DOUT_W+n];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkg_ok && !pkg_ok_q) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        accept  = header_ok;
        reject  = !header_ok;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkg_ok_q      <= 1'b0;
      shadow        <= '0;
      joint_q       <= '0;
      enable_q      <= '0;
      vout_q        <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      pkg_ok_q      <= pkg_ok;
      frame_valid_q <= accept;
      frame_err_q   <= reject;
      if (capture) begin
        shadow <= rx_data;
      end
      if (accept) begin
        joint_q  <= joint_rx;
        enable_q <= enable_rx;
        vout_q   <= vout_rx;
        dout_q   <= dout_rx;
      end
      if (reject && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  frame_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (accept),
    .timeout (wdt_timeout)
  );

  // setPoint deliberately bypasses the watchdog and keeps its last value.
  assign jointFreqCmd = wdt_timeout ? '0 : joint_q;
  assign jointEnable  = wdt_timeout ? '0 : enable_q;
  assign dout         = wdt_timeout ? '0 : dout_q;
  assign setPoint     = vout_q;
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_spi_rx_frame_decoder.sv
// Bench for spi_rx_frame_decoder: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_spi_rx_frame_decoder;

  localparam logic [31:0] WDT  = 32'd16;
  localparam logic [95:0] GOOD = 96'h74697277_A1177AA1_7A17_80_A5;
  localparam logic [95:0] BAD  = 96'h61746164_A1177AA1_7A17_80_A5;
  localparam logic [95:0] ALT  = 96'h74697277_01020304_0506_00_3C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkg_ok = 1'b0;
  logic [95:0] rx_data = '0;

  logic [31:0] jointFreqCmd;
  logic [0:0]  jointEnable;
  logic [15:0] setPoint;
  logic [7:0]  dout;
  logic        frame_valid, frame_err, wdt_timeout;
  logic [15:0] err_cnt;

  spi_rx_frame_decoder #(
    .BUFFER_SIZE(96),
    .HEADER_RX  (32'h77726974),
    .JOINTS     (1),
    .VOUTS      (1),
    .DOUTS      (8),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .pkg_ok      (pkg_ok),
    .jointFreqCmd(jointFreqCmd),
    .jointEnable (jointEnable),
    .setPoint    (setPoint),
    .dout        (dout),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .wdt_timeout (wdt_timeout),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_seen = 0;
  int fe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are read as a byte stream, fields assembled little-endian.
  logic [31:0] m_cmd;
  logic [15:0] m_sp;
  logic        m_en;
  logic [7:0]  m_dout;
  logic        m_fv, m_fe;
  logic [15:0] m_err;
  int unsigned m_wdt;
  logic        m_prev, m_pending;
  logic [95:0] m_frame;

  function automatic logic [7:0] byte_at(input logic [95:0] f, input int i);
    return f[95-8*i -: 8];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cmd = '0; m_sp = '0; m_en = 1'b0; m_dout = '0;
      m_fv = 1'b0; m_fe = 1'b0; m_err = '0; m_wdt = 0;
      m_prev = 1'b0; m_pending = 1'b0; m_frame = '0;
    end else begin
      automatic bit accepted = 1'b0;
      m_fv = 1'b0;
      m_fe = 1'b0;
      if (m_pending) begin
        m_pending = 1'b0;
        if ({byte_at(m_frame, 3), byte_at(m_frame, 2), byte_at(m_frame, 1), byte_at(m_frame, 0)} == 32'h77726974) begin
          m_cmd  = {byte_at(m_frame, 7), byte_at(m_frame, 6), byte_at(m_frame, 5), byte_at(m_frame, 4)};
          m_sp   = {byte_at(m_frame, 9), byte_at(m_frame, 8)};
          m_en   = m_frame[95-8*10];
          m_dout = byte_at(m_frame, 11);
          m_fv   = 1'b1;
          m_wdt  = WDT;
          accepted = 1'b1;
        end else begin
          m_fe = 1'b1;
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
      end else if (pkg_ok && !m_prev) begin
        m_frame   = rx_data;
        m_pending = 1'b1;
      end
      if (!accepted && m_wdt > 0) m_wdt = m_wdt - 1;
      m_prev = pkg_ok;
    end
  end

  always @(negedge clk) begin
    automatic bit expired = (m_wdt == 0);
    check("cyc_jointFreqCmd", jointFreqCmd, expired ? 32'h0 : m_cmd);
    check("cyc_jointEnable", {31'b0, jointEnable}, {31'b0, expired ? 1'b0 : m_en});
    check("cyc_dout", {24'b0, dout}, {24'b0, expired ? 8'h0 : m_dout});
    check("cyc_setPoint", {16'b0, setPoint}, {16'b0, m_sp});
    check("cyc_frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
    check("cyc_frame_err", {31'b0, frame_err}, {31'b0, m_fe});
    check("cyc_wdt_timeout", {31'b0, wdt_timeout}, {31'b0, expired});
    check("cyc_err_cnt", {16'b0, err_cnt}, {16'b0, m_err});
    if (frame_valid === 1'b1) fv_seen++;
    if (frame_err === 1'b1) fe_seen++;
  end

  // Raise pkg_ok with a frame for hold cycles, then drop it for one cycle.
  task automatic send(input logic [95:0] data, input int hold);
    rx_data = data;
    pkg_ok  = 1'b1;
    repeat (hold) @(negedge clk);
    pkg_ok = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_cmd", jointFreqCmd, 32'h0);
    check("rst_timeout", {31'b0, wdt_timeout}, 32'd1);
    check("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Header mismatch straight after reset.
    send(BAD, 1);
    check("bad_frame_err", {31'b0, frame_err}, 32'd1);
    check("bad_err_cnt", {16'b0, err_cnt}, 32'd1);
    check("bad_timeout", {31'b0, wdt_timeout}, 32'd1);
    check("bad_cmd", jointFreqCmd, 32'h0);
    repeat (2) @(negedge clk);

    // Valid frame: latency and field decoding.
    rx_data = GOOD;
    pkg_ok  = 1'b1;
    @(negedge clk);
    check("lat_cmd_not_yet", jointFreqCmd, 32'h0);
    check("lat_fv_not_yet", {31'b0, frame_valid}, 32'd0);
    @(negedge clk);
    pkg_ok = 1'b0;
    check("good_cmd", jointFreqCmd, 32'hA17A17A1);
    check("good_setPoint", {16'b0, setPoint}, 32'h177A);
    check("good_enable", {31'b0, jointEnable}, 32'd1);
    check("good_dout", {24'b0, dout}, 32'hA5);
    check("good_fv", {31'b0, frame_valid}, 32'd1);
    check("good_timeout", {31'b0, wdt_timeout}, 32'd0);

    // Watchdog expiry exactly WDT cycles after the reload.
    repeat (15) @(negedge clk);
    check("wdt_before", {31'b0, wdt_timeout}, 32'd0);
    @(negedge clk);
    check("wdt_expired", {31'b0, wdt_timeout}, 32'd1);
    check("wdt_cmd", jointFreqCmd, 32'h0);
    check("wdt_enable", {31'b0, jointEnable}, 32'd0);
    check("wdt_dout", {24'b0, dout}, 32'h0);
    check("wdt_setPoint", {16'b0, setPoint}, 32'h177A);

    // Long pkg_ok high, then a second edge: exactly two captures.
    base = fv_seen;
    rx_data = ALT;
    pkg_ok  = 1'b1;
    repeat (50) @(negedge clk);
    pkg_ok = 1'b0;
    repeat (3) @(negedge clk);
    pkg_ok = 1'b1;
    repeat (4) @(negedge clk);
    pkg_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_pulses", fv_seen - base, 32'd2);
    check("alt_cmd", jointFreqCmd, 32'h04030201);
    check("alt_setPoint", {16'b0, setPoint}, 32'h0605);
    check("alt_enable", {31'b0, jointEnable}, 32'd0);
    check("alt_dout", {24'b0, dout}, 32'h3C);

    // Reset while the captured frame is being checked.
    base = fv_seen;
    rx_data = GOOD;
    pkg_ok  = 1'b1;
    @(negedge clk);
    rst_n  = 1'b0;
    pkg_ok = 1'b0;
    @(negedge clk);
    check("midrst_fv", {31'b0, frame_valid}, 32'd0);
    check("midrst_cmd", jointFreqCmd, 32'h0);
    check("midrst_setPoint", {16'b0, setPoint}, 32'h0);
    check("midrst_timeout", {31'b0, wdt_timeout}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_pulse", fv_seen - base, 32'd0);

    // Error counter saturation: preload close to the top, then overrun it.
    force dut.err_cnt_q = 16'hFFFD;
    m_err = 16'hFFFD;
    #1 release dut.err_cnt_q;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(BAD, 1);
    check("sat_err_cnt", {16'b0, err_cnt}, 32'hFFFF);
    send(GOOD, 1);
    check("sat_good_fv", {31'b0, frame_valid}, 32'd1);
    check("sat_good_cmd", jointFreqCmd, 32'hA17A17A1);
    check("sat_err_hold", {16'b0, err_cnt}, 32'hFFFF);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
